// File: rtl/aes_block_source_if.sv
// aes_block_source_if: plaintext issue and expected-block handshakes of the AES loopback source
interface aes_block_source_if;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_block;
  logic         exp_pop;
  logic         exp_valid;
  logic [127:0] exp_block;
  modport master (
    output pt_valid, pt_block, exp_valid, exp_block,
    input  pt_ready, exp_pop
  );
  modport slave (
    input  pt_valid, pt_block, exp_valid, exp_block,
    output pt_ready, exp_pop
  );
endinterface

// File: rtl/aes_block_source.sv
// aes_block_source: LFSR plaintext generator with in-order expected-block FIFO for AES loopback checking
module aes_block_source #(
  parameter int           DEPTH = 4,
  parameter logic [127:0] SEED  = 128'h1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [15:0]               num_blocks,
  aes_block_source_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               issued_cnt,
  output logic                      fifo_full,
  output logic                      underflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t         state_q, state_d;
  logic [127:0]   lfsr_q, lfsr_d;
  logic [15:0]    cnt_q, cnt_d, nblk_q, nblk_d;
  logic           uf_q, uf_d;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic [127:0]   mem_q [DEPTH];
  logic [127:0]   mem_d [DEPTH];
  logic           push, pop;
  assign fifo_full     = count_q == CW'(DEPTH);
  assign bus.exp_valid = count_q != '0;
  assign bus.exp_block = bus.exp_valid ? mem_q[rd_q] : '0;
  assign bus.pt_valid  = state_q == ISSUE && !fifo_full;
  assign bus.pt_block  = state_q == ISSUE ? lfsr_q : '0;
  assign busy          = state_q == ISSUE || state_q == DRAIN;
  assign done          = state_q == DONE;
  assign issued_cnt    = cnt_q;
  assign underflow_err = uf_q;
  assign push          = bus.pt_valid && bus.pt_ready;
  assign pop           = bus.exp_pop && bus.exp_valid;
  // Next-state: transfers feed the FIFO and LFSR, pops drain it, an accepted start reinitialises the run
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    nblk_d  = nblk_q;
    uf_d    = uf_q || (bus.exp_pop && !bus.exp_valid);
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    mem_d   = mem_q;
    if (push) begin
      mem_d[wr_q] = lfsr_q;
      wr_d        = wr_q + AW'(1);
      lfsr_d      = {lfsr_q[126:0], lfsr_q[127] ^ lfsr_q[125] ^ lfsr_q[100] ^ lfsr_q[98]};
      cnt_d       = cnt_q + 16'd1;
    end
    if (pop) rd_d = rd_q + AW'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d = num_blocks != '0 ? ISSUE : DONE;
        lfsr_d  = SEED;
        cnt_d   = '0;
        nblk_d  = num_blocks;
        uf_d    = 1'b0;
        wr_d    = '0;
        rd_d    = '0;
        count_d = '0;
      end
      ISSUE:   state_d = push && cnt_q + 16'd1 == nblk_q ? DRAIN : ISSUE;
      DRAIN:   state_d = count_q == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // State register with asynchronous return to the idle, empty, seeded condition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      nblk_q  <= '0;
      uf_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      nblk_q  <= nblk_d;
      uf_q    <= uf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_aes_block_source.sv
// tb_aes_block_source: table-driven runs plus corner sequences, scoreboarded against an LFSR/FIFO model
module tb_aes_block_source;
  localparam logic [127:0] SEED = 128'h1;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_blocks = '0;
  logic        busy, done, fifo_full, underflow_err;
  logic [15:0] issued_cnt;
  aes_block_source_if bus();
  aes_block_source #(.DEPTH(4), .SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_blocks(num_blocks), .bus(bus.master),
    .busy(busy), .done(done), .issued_cnt(issued_cnt), .fifo_full(fifo_full), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  int           tests = 0, fails = 0;
  logic [127:0] m_lfsr = SEED;
  logic [127:0] q[$];
  int           m_iss = 0, xfers = 0, dones = 0;
  logic         prev_hold = 1'b0;
  logic [127:0] prev_blk = '0;
  typedef struct {
    logic [15:0] num;
    logic [7:0]  rdy;
    logic [7:0]  pop;
    bit          raw;
    logic        exp_uf;
  } vec_t;
  vec_t vt[7];
  function automatic logic [127:0] step_f(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic mon();
    chk("exp_valid", 128'(bus.exp_valid), 128'(q.size() != 0));
    chk("fifo_full", 128'(fifo_full), 128'(q.size() == 4));
    chk("issued_cnt", 128'(issued_cnt), 128'(m_iss));
    if (prev_hold) begin
      chk("pt_valid_hold", 128'(bus.pt_valid), 128'(1));
      chk("pt_block_hold", bus.pt_block, prev_blk);
    end
    if (done) dones++;
    if (q.size() == 0) chk("exp_block_empty", bus.exp_block, '0);
    if (bus.exp_pop && bus.exp_valid && q.size() != 0) chk("exp_block", bus.exp_block, q.pop_front());
    if (bus.pt_valid && bus.pt_ready) begin
      chk("pt_block", bus.pt_block, m_lfsr);
      q.push_back(m_lfsr);
      m_lfsr = step_f(m_lfsr);
      m_iss++;
      xfers++;
    end
    prev_hold = bus.pt_valid && !bus.pt_ready;
    prev_blk  = bus.pt_block;
  endtask
  task automatic tick();
    #1;
    mon();
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_ctl", 128'({bus.pt_valid, bus.exp_valid, busy, done, fifo_full, underflow_err, issued_cnt}), '0);
    chk("reset_pt_block", bus.pt_block, '0);
    chk("reset_exp_block", bus.exp_block, '0);
    q.delete();
    m_lfsr = SEED;
    m_iss = 0;
    xfers = 0;
    prev_hold = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_blocks = n;
    tick();
    start = 1'b0;
    m_lfsr = SEED;
    m_iss = 0;
    xfers = 0;
    dones = 0;
    q.delete();
  endtask
  task automatic run_to_done(input logic [7:0] rdy, input logic [7:0] pop, input bit raw);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      bus.pt_ready = rdy[i % 8];
      bus.exp_pop  = pop[i % 8] && (raw || q.size() != 0);
      tick();
      seen = dones > 0;
    end
    bus.pt_ready = 1'b0;
    bus.exp_pop  = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: done not seen, xfers %0d", xfers);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{num: 16'd3, rdy: 8'hFF, pop: 8'hFF, raw: 1'b0, exp_uf: 1'b0};
    vt[1] = '{num: 16'd6, rdy: 8'hFF, pop: 8'h01, raw: 1'b0, exp_uf: 1'b0};
    vt[2] = '{num: 16'd2, rdy: 8'h12, pop: 8'h40, raw: 1'b0, exp_uf: 1'b0};
    vt[3] = '{num: 16'd5, rdy: 8'hAA, pop: 8'h55, raw: 1'b0, exp_uf: 1'b0};
    vt[4] = '{num: 16'd4, rdy: 8'hFF, pop: 8'hFF, raw: 1'b1, exp_uf: 1'b1};
    vt[5] = '{num: 16'd0, rdy: 8'hFF, pop: 8'hFF, raw: 1'b0, exp_uf: 1'b0};
    vt[6] = '{num: 16'd9, rdy: 8'h6D, pop: 8'h33, raw: 1'b0, exp_uf: 1'b0};
    bus.pt_ready = 1'b0;
    bus.exp_pop  = 1'b0;
    @(negedge clk);
    do_reset();
    do_start(16'd3);
    bus.pt_ready = 1'b1;
    repeat (3) begin
      chk("a_pt_valid", 128'(bus.pt_valid), 128'(1));
      tick();
    end
    bus.pt_ready = 1'b0;
    chk("a_drain_pt_valid", 128'(bus.pt_valid), 128'(0));
    chk("a_drain_exp_block", bus.exp_block, 128'h1);
    chk("a_issued", 128'(issued_cnt), 128'(3));
    chk("a_busy", 128'(busy), 128'(1));
    chk("a_xfers", 128'(xfers), 128'(3));
    repeat (3) begin
      bus.exp_pop = 1'b1;
      tick();
    end
    bus.exp_pop = 1'b0;
    chk("a_empty", 128'(bus.exp_valid), 128'(0));
    chk("a_done_early", 128'(done), 128'(0));
    tick();
    chk("a_done", 128'(done), 128'(1));
    tick();
    chk("a_done_low", 128'(done), 128'(0));
    chk("a_idle", 128'(busy), 128'(0));
    do_start(16'd6);
    bus.pt_ready = 1'b1;
    repeat (4) tick();
    chk("b_full", 128'(fifo_full), 128'(1));
    chk("b_pt_valid", 128'(bus.pt_valid), 128'(0));
    chk("b_pt_block", bus.pt_block, 128'h10);
    repeat (2) tick();
    chk("b_pt_block_hold", bus.pt_block, 128'h10);
    chk("b_xfers4", 128'(xfers), 128'(4));
    bus.exp_pop = 1'b1;
    tick();
    bus.exp_pop = 1'b0;
    chk("b_pt_valid_again", 128'(bus.pt_valid), 128'(1));
    tick();
    chk("b_xfers5", 128'(xfers), 128'(5));
    chk("b_refull", 128'(bus.pt_valid), 128'(0));
    run_to_done(8'hFF, 8'hFF, 1'b0);
    chk("b_xfers6", 128'(xfers), 128'(6));
    tick();
    bus.exp_pop = 1'b1;
    tick();
    bus.exp_pop = 1'b0;
    chk("c_uf_set", 128'(underflow_err), 128'(1));
    repeat (3) tick();
    chk("c_uf_hold", 128'(underflow_err), 128'(1));
    do_start(16'd2);
    chk("c_uf_clear", 128'(underflow_err), 128'(0));
    run_to_done(8'hFF, 8'hFF, 1'b0);
    tick();
    do_start(16'd0);
    chk("d_pt_valid", 128'(bus.pt_valid), 128'(0));
    chk("d_done", 128'(done), 128'(1));
    tick();
    chk("d_done_low", 128'(done), 128'(0));
    chk("d_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 7; i++) begin
      do_start(vt[i].num);
      run_to_done(vt[i].rdy, vt[i].pop, vt[i].raw);
      chk($sformatf("v%0d_xfers", i), 128'(xfers), 128'(vt[i].num));
      chk($sformatf("v%0d_uf", i), 128'(underflow_err), 128'(vt[i].exp_uf));
      tick();
      chk($sformatf("v%0d_done_once", i), 128'(dones), 128'(1));
      chk($sformatf("v%0d_idle", i), 128'(busy), 128'(0));
    end
    do_start(16'd5);
    bus.pt_ready = 1'b1;
    repeat (2) tick();
    chk("e_xfers2", 128'(xfers), 128'(2));
    do_reset();
    do_start(16'd1);
    run_to_done(8'hFF, 8'hFF, 1'b0);
    chk("e_xfers1", 128'(xfers), 128'(1));
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
